// File: rtl/io_port_bridge.sv
// io_port_bridge
// Sits on the far side of a CPU's external I/O pins. Host bytes are queued,
// presented on input_port and announced with a one-cycle interrupt pulse that
// is followed by a quiet gap long enough for the ISR to execute its IN.
// CPU OUT writes are queued and drained to the host over a valid/ready stream.
module io_port_bridge #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int INTR_GAP  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  host_in_data,
    input  logic                        host_in_valid,
    output logic                        host_in_ready,
    output logic [7:0]                  input_port,
    output logic                        interrupt,
    input  logic [7:0]                  cpu_out,
    input  logic                        cpu_out_we,
    output logic [7:0]                  host_out_data,
    output logic                        host_out_valid,
    input  logic                        host_out_ready,
    output logic                        out_overflow,
    output logic [$clog2(IN_DEPTH):0]   in_count
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = OUT_AW + 1;
    localparam int GAP_W  = $clog2(INTR_GAP) + 1;

    localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
    localparam logic [IN_CW-1:0]  IN_CNT_ONE   = IN_CW'(1);
    localparam logic [IN_AW-1:0]  IN_PTR_ONE   = IN_AW'(1);
    localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_CNT_ONE  = OUT_CW'(1);
    localparam logic [OUT_AW-1:0] OUT_PTR_ONE  = OUT_AW'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD     = GAP_W'(INTR_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE      = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP
    } state_t;

    // Inbound FIFO storage and bookkeeping
    logic [7:0]        in_mem_q [IN_DEPTH];
    logic [IN_AW-1:0]  in_wr_q, in_wr_d;
    logic [IN_AW-1:0]  in_rd_q, in_rd_d;
    logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
    logic              in_full;
    logic              in_empty;
    logic              in_push;
    logic              in_pop;

    // Delivery FSM state
    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        port_q, port_d;
    logic              intr_q, intr_d;

    // Outbound FIFO storage and bookkeeping
    logic [7:0]        out_mem_q [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_q, out_wr_d;
    logic [OUT_AW-1:0] out_rd_q, out_rd_d;
    logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_full;
    logic              out_empty;
    logic              out_push;
    logic              out_pop;

    assign in_full       = (in_cnt_q == IN_FULL_CNT);
    assign in_empty      = (in_cnt_q == '0);
    assign host_in_ready = !in_full && !reset;
    assign in_push       = host_in_valid && host_in_ready;
    assign in_count      = in_cnt_q;
    assign input_port    = port_q;
    assign interrupt     = intr_q;

    assign out_full       = (out_cnt_q == OUT_FULL_CNT);
    assign out_empty      = (out_cnt_q == '0);
    assign host_out_valid = !out_empty;
    assign host_out_data  = out_mem_q[out_rd_q];
    assign out_overflow   = ovf_q;
    assign out_pop        = !out_empty && host_out_ready;
    // A write into a full FIFO still lands if the host frees a slot this cycle
    assign out_push       = cpu_out_we && (!out_full || out_pop);

    // Inbound pointer and occupancy update from this cycle's push/pop
    always_comb begin
        in_wr_d  = in_wr_q;
        in_rd_d  = in_rd_q;
        in_cnt_d = in_cnt_q;
        if (in_push) begin
            in_wr_d = in_wr_q + IN_PTR_ONE;
        end
        if (in_pop) begin
            in_rd_d = in_rd_q + IN_PTR_ONE;
        end
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + IN_CNT_ONE;
            2'b01:   in_cnt_d = in_cnt_q - IN_CNT_ONE;
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    // Delivery sequencing: pop, let input_port settle, pulse, then hold off
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        port_d  = port_q;
        in_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!in_empty) begin
                    in_pop  = 1'b1;
                    port_d  = in_mem_q[in_rd_q];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                gap_d   = GAP_LOAD;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        intr_d = (state_d == ST_PULSE);
    end

    // Outbound pointers, occupancy and the sticky dropped-write flag
    always_comb begin
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        ovf_d     = ovf_q;
        if (out_push) begin
            out_wr_d = out_wr_q + OUT_PTR_ONE;
        end
        if (out_pop) begin
            out_rd_d = out_rd_q + OUT_PTR_ONE;
        end
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + OUT_CNT_ONE;
            2'b01:   out_cnt_d = out_cnt_q - OUT_CNT_ONE;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (cpu_out_we && !out_push) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO data arrays; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem_q[in_wr_q] <= host_in_data;
        end
        if (out_push) begin
            out_mem_q[out_wr_q] <= cpu_out;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_cnt_q  <= '0;
            state_q   <= ST_IDLE;
            gap_q     <= '0;
            port_q    <= '0;
            intr_q    <= 1'b0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_cnt_q  <= in_cnt_d;
            state_q   <= state_d;
            gap_q     <= gap_d;
            port_q    <= port_d;
            intr_q    <= intr_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_io_port_bridge;

    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;
    localparam int INTR_GAP  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] host_in_data;
    logic       host_in_valid;
    logic       host_in_ready;
    logic [7:0] input_port;
    logic       interrupt;
    logic [7:0] cpu_out;
    logic       cpu_out_we;
    logic [7:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready;
    logic       out_overflow;
    logic [$clog2(IN_DEPTH):0] in_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: byte queues plus the timing of the next delivery
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic [7:0] m_port;
    int         intr_at;
    int         t_free;
    bit         m_ovf;
    bit         last_in_acc;

    io_port_bridge #(
        .IN_DEPTH (IN_DEPTH),
        .OUT_DEPTH(OUT_DEPTH),
        .INTR_GAP (INTR_GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_in_data  (host_in_data),
        .host_in_valid (host_in_valid),
        .host_in_ready (host_in_ready),
        .input_port    (input_port),
        .interrupt     (interrupt),
        .cpu_out       (cpu_out),
        .cpu_out_we    (cpu_out_we),
        .host_out_data (host_out_data),
        .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .out_overflow  (out_overflow),
        .in_count      (in_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model
    task automatic applyStimulus(input logic rst, input logic iv,
                                 input logic [7:0] id, input logic we,
                                 input logic [7:0] od, input logic ordy);
        bit in_acc;
        bit o_pop;
        bit o_acc;
        @(negedge clk);
        reset          = rst;
        host_in_valid  = iv;
        host_in_data   = id;
        cpu_out_we     = we;
        cpu_out        = od;
        host_out_ready = ordy;
        #1;
        checkOutput("host_in_ready", 32'(host_in_ready),
                    32'(!rst && (in_q.size() < IN_DEPTH)));
        checkOutput("in_count", 32'(in_count), 32'(in_q.size()));
        checkOutput("input_port", 32'(input_port), 32'(m_port));
        checkOutput("interrupt", 32'(interrupt), 32'(cyc == intr_at));
        checkOutput("host_out_valid", 32'(host_out_valid), 32'(out_q.size() > 0));
        if (out_q.size() > 0) begin
            checkOutput("host_out_data", 32'(host_out_data), 32'(out_q[0]));
        end
        checkOutput("out_overflow", 32'(out_overflow), 32'(m_ovf));

        in_acc = !rst && iv && (in_q.size() < IN_DEPTH);
        if (rst) begin
            in_q.delete();
            out_q.delete();
            m_port  = 8'h00;
            intr_at = -1;
            t_free  = cyc + 1;
            m_ovf   = 1'b0;
        end else begin
            if (in_q.size() > 0 && cyc >= t_free) begin
                m_port  = in_q.pop_front();
                intr_at = cyc + 2;
                t_free  = cyc + INTR_GAP + 3;
            end
            if (in_acc) begin
                in_q.push_back(id);
            end
            o_pop = (out_q.size() > 0) && ordy;
            o_acc = we && ((out_q.size() < OUT_DEPTH) || o_pop);
            if (we && !o_acc) begin
                m_ovf = 1'b1;
            end
            if (o_pop) begin
                void'(out_q.pop_front());
            end
            if (o_acc) begin
                out_q.push_back(od);
            end
        end
        last_in_acc = in_acc;
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ordy);
        end
    endtask

    initial begin
        logic [7:0] burst [6];
        int         idx;
        int         guard;

        reset          = 1'b1;
        host_in_valid  = 1'b0;
        host_in_data   = 8'h00;
        cpu_out_we     = 1'b0;
        cpu_out        = 8'h00;
        host_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        m_port  = 8'h00;
        intr_at = -1;
        t_free  = 0;
        m_ovf   = 1'b0;

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b0);

        $display("[TB] single byte delivery");
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
        idle(16, 1'b0);

        $display("[TB] three back-to-back bytes");
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
        idle(40, 1'b0);

        $display("[TB] six bytes into a four-entry queue");
        burst = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 200) begin
            applyStimulus(1'b0, 1'b1, burst[idx], 1'b0, 8'h00, 1'b0);
            if (last_in_acc) idx++;
            guard++;
        end
        if (idx < 6) checkOutput("burst_accept_timeout", 32'(idx), 32'd6);
        idle(80, 1'b0);

        $display("[TB] outbound overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hA0 + 8'(i), 1'b0);
        end
        idle(2, 1'b0);
        idle(6, 1'b1);

        $display("[TB] outbound write while full with a pop");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hB0 + 8'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'hB7, 1'b1);
        idle(1, 1'b0);
        idle(6, 1'b1);

        $display("[TB] reset during gap");
        applyStimulus(1'b0, 1'b1, 8'hD1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hD2, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hD3, 1'b0, 8'h00, 1'b0);
        idle(6, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(30, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 299) == 0),
                          1'($urandom_range(0, 2) != 0),
                          8'($urandom),
                          1'($urandom_range(0, 1)),
                          8'($urandom),
                          1'($urandom_range(0, 2) == 0));
        end
        idle(60, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
Peripheral that sits on the opposite side of the CPU's external I/O pins: `interrupt`, `input_port` and `OUT`.
- Inbound: buffers bytes from a host-side valid/ready stream, presents each byte on `input_port` and signals it to the CPU with a one-cycle `interrupt` pulse. A guaranteed gap follows each pulse so the ISR can run its IN instruction.
- Outbound: captures CPU OUT writes into a FIFO that drains to a host-side valid/ready stream.

Parameters:
IN_DEPTH, 4, inbound FIFO entries (power of 2, ≥2)
OUT_DEPTH, 4, outbound FIFO entries (power of 2, ≥2)
INTR_GAP, 8, idle cycles enforced after each interrupt pulse (≥1)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high
host_in_data  in  8  byte to deliver to CPU
host_in_valid  in  1  host_in_data valid
host_in_ready  out  1  = !in_full && !reset (combinational)
input_port  out  8  registered byte driven to CPU input_port
interrupt  out  1  registered one-cycle pulse to CPU interrupt
cpu_out  in  8  CPU OUT value
cpu_out_we  in  1  one-cycle strobe, CPU OUT instruction at writeback
host_out_data  out  8  head of outbound FIFO (show-ahead)
host_out_valid  out  1  = !out_empty
host_out_ready  in  1  host consumes head
out_overflow  out  1  sticky: a cpu_out_we was dropped
in_count  out  $clog2(IN_DEPTH)+1  inbound occupancy

Behaviour:
Clocking and reset:
- One clock `clk`; reset is synchronous and active-high, port named `reset`.
- On reset: both FIFOs empty, pointers 0, FSM=IDLE, gap counter 0, input_port=0, interrupt=0, out_overflow=0.
- Resulting output values on reset: host_out_valid=0, in_count=0, host_in_ready=0 while reset high.
- Reset mid-delivery aborts everything; queued data is lost.

Inbound FIFO:
- Push on host_in_valid && host_in_ready.
- No push while full; ready is already low, so there is no overwrite.
- in_count counts pushes minus pops, updated at the clock edge.

Delivery FSM (IDLE, SETUP, PULSE, GAP):
- IDLE: if in_count≠0, pop the head into input_port and go to SETUP; otherwise stay.
- SETUP: interrupt=0 for one cycle so input_port is stable before the pulse; go to PULSE.
- PULSE: interrupt=1 for exactly this cycle; load the gap counter with INTR_GAP-1; go to GAP.
- GAP: decrement the counter; when it is 0, go to IDLE.
- input_port holds its value until the next pop, i.e. it remains valid throughout the ISR.

Timing:
- Push accepted at edge E0 into an empty FIFO in IDLE: input_port updates after E1, interrupt is high between E2 and E3.
- Back-to-back queued bytes produce pulses every INTR_GAP+3 cycles.
- A push in the same cycle as the FSM pop is allowed when not full; in_count is unchanged net.

Outbound FIFO:
- Push cpu_out on cpu_out_we.
- Pop on host_out_valid && host_out_ready.
- Full with a simultaneous pop: the write is accepted.
- Full without a pop: the write is dropped, contents are unchanged, out_overflow is set to 1 and held until reset.
- Empty with cpu_out_we: data appears on host_out_data with host_out_valid=1 the following cycle; there is no same-cycle bypass.
- Pointers wrap modulo depth. Occupancy counters are wide enough to distinguish full from empty.

Widths:
- All data is 8-bit.
- The gap counter is $clog2(INTR_GAP)+1 bits, so it can hold INTR_GAP-1.

Test Plan:
1. Reset, then push 0x5A at edge E0 → input_port=0x5A after E1; interrupt=1 for exactly one cycle after E2; interrupt=0 for the following 8 cycles.
2. Push 0x11,0x22,0x33 back-to-back (INTR_GAP=8) → three interrupt pulses 11 cycles apart; input_port equals 0x11/0x22/0x33 during each respective pulse; in_count reaches 0 after the third pop.
3. Hold host_out_ready=0 and push 6 inbound bytes continuously → host_in_ready drops when in_count=4; no byte lost or duplicated; all 6 delivered in order.
4. With host_out_ready=0, strobe cpu_out_we with 0xA0..0xA4 → FIFO holds 0xA0..0xA3; out_overflow=1. Then assert ready → host sees 0xA0,0xA1,0xA2,0xA3 in order; out_overflow stays 1.
5. Outbound FIFO full: strobe cpu_out_we=0xB7 in the same cycle as a pop → 0xB7 accepted as the last entry; out_overflow stays 0.
6. Assert reset during GAP with 2 bytes queued → next cycle interrupt=0, input_port=0, in_count=0, FSM IDLE; no further pulses.
